wb_uart_mc: RTL and testbench
=============================

Name: wb_uart_mc

Overview:
- Multi-channel Wishbone B3 slave UART. Generalises the tile's single UART to CHANNELS independent 8N1 ports.
- Each channel has parametrised TX/RX FIFOs, a runtime baud divisor, status/error flags and a per-channel interrupt.
- Sits behind the compute-tile network adapter's Wishbone master port, or on the tile bus as a slave.

Parameters:
- CHANNELS, 2: number of UART channels, 1..16.
- FIFO_DEPTH, 8: entries per TX and per RX FIFO; power of two, 2..256.
- DIV_RESET, 867: reset baud divisor; bit period = DIV+1 clk cycles.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- wb_adr_i, input, 32: byte address; [4:2] = register index, [8:5] = channel index.
- wb_dat_i, input, 32: write data.
- wb_sel_i, input, 4: byte selects; only bit 0 is honoured for DATA.
- wb_we_i, input, 1: write enable.
- wb_cyc_i, input, 1: bus cycle.
- wb_stb_i, input, 1: strobe.
- wb_dat_o, output, 32: read data.
- wb_ack_o, output, 1: access complete.
- wb_err_o, output, 1: access error.
- uart_tx, output, CHANNELS: serial out per channel; idles high.
- uart_rx, input, CHANNELS: serial in per channel; asynchronous to clk.
- irq, output, CHANNELS: level interrupt per channel.

Behaviour:
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, uart_tx=all 1, irq=0.
- Reset state: FIFOs empty, divisor=DIV_RESET, CTRL enables=1, IRQ enables=0, flags clear.
- Reset mid-frame aborts the frame immediately and drives TX high.

Bus protocol:
- Request = cyc&stb. One cycle later exactly one of ack or err pulses for one cycle, then the slave idles one cycle. Latency 1; no back-to-back responses.
- err on: channel index >= CHANNELS, or register index > 3. Errored accesses have no side effects.
- Side effects occur once, in the request cycle that produces the response.

Registers (per channel):
- 0 DATA
  - Write: push wb_dat_i[7:0] to TX FIFO. If the FIFO is full, the write is dropped and TXOVF is set.
  - Read: pop RX FIFO and return {24'b0, byte}. If the FIFO is empty, return 0 with no pop.
- 1 STATUS (read-only): [0] rx_nonempty, [1] tx_full, [2] tx_idle (FIFO empty and shifter idle), [3] RXOVR, [4] FRAMING, [5] TXOVF, [15:8] RX fill count.
- 2 CTRL (RW): [15:0] divisor, [16] tx_en, [17] rx_en, [18] irq_rx_en, [19] irq_txempty_en, [20] irq_err_en. A divisor change takes effect at the next frame start.
- 3 FLAGS: read returns the STATUS bits [5:3]; writing 1 clears each corresponding bit.

TX path:
- States IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
- Each state lasts DIV+1 cycles; the bit counter wraps 7 -> STOP.
- IDLE pops the FIFO when tx_en=1 and the FIFO is non-empty. Back-to-back frames have no extra idle bit.
- tx_en=0 lets the current frame finish, then holds IDLE.

RX path:
- 2-flop synchroniser on uart_rx.
- States IDLE -> START -> DATA -> STOP.
- A falling edge in IDLE (rx_en=1) enters START.
- Sample at (DIV+1)>>1 cycles into START. If the line is high, return to IDLE (glitch). Then sample every DIV+1 cycles.
- Stop bit low: set FRAMING, discard the byte, wait for the line to go high before IDLE.
- FIFO full at the stop sample: set RXOVR, drop the new byte.

FIFO boundary conditions:
- A simultaneous push and pop when full or empty succeeds; the count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Count is log2(FIFO_DEPTH)+1 bits.

Interrupt:
- irq[c] = (irq_rx_en & rx_nonempty) | (irq_txempty_en & tx_idle) | (irq_err_en & (RXOVR|FRAMING|TXOVF)).
- Registered; asserts 1 cycle after the condition.

Decomposition:
- Package wb_uart_mc_pkg holds:
  - register index constants REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_FLAGS=3;
  - STATUS/CTRL bit positions;
  - typedef enum uart_state_t {IDLE, START, DATA, STOP};
  - typedef struct ctrl_t.
- Sub-module uart_channel holds one channel's FIFOs, TX/RX FSMs, flags and irq. It is instantiated CHANNELS times via generate.
- The top holds address decode, the ack/err pipeline and the read mux.

Test Plan:
- Reset, then read CTRL ch0 -> 0x0003_0363, ack 1 cycle after stb. Read ch3 (CHANNELS=2) -> err=1, ack=0.
- Set divisor=3, write 0xA5 to DATA ch1 -> uart_tx[1] low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high. STATUS tx_idle=1 afterwards.
- Loop uart_tx[0]->uart_rx[0], divisor=3, write 0x3C, 0x81 -> after 2 frames STATUS rx count=2. DATA reads return 0x3C then 0x81; next read returns 0.
- FIFO_DEPTH=8: write 9 bytes with tx_en=0 -> tx_full=1, TXOVF=1. Write FLAGS 0x20 -> TXOVF=0. Set tx_en -> exactly 8 frames sent.
- Drive rx with a stop bit=0 -> FRAMING=1, rx count stays 0, and irq asserts if irq_err_en=1.
- Drive a 1-cycle low glitch on rx -> no byte, no flag. 9 valid frames into a full RX FIFO -> RXOVR=1, 9th byte lost.

Source files
------------

// File: rtl/wb_uart_mc_pkg.sv
// wb_uart_mc_pkg: register map, bit positions and shared types for the multi-channel UART
package wb_uart_mc_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_FLAGS = 2'd3;
  localparam int ST_RX_NE = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_TX_IDLE = 2;
  localparam int ST_RXOVR = 3;
  localparam int ST_FRAMING = 4;
  localparam int ST_TXOVF = 5;
  localparam int ST_RX_CNT = 8;
  localparam int CT_DIV = 0;
  localparam int CT_TX_EN = 16;
  localparam int CT_RX_EN = 17;
  localparam int CT_IRQ_RX = 18;
  localparam int CT_IRQ_TXE = 19;
  localparam int CT_IRQ_ERR = 20;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  typedef struct packed {
    logic irq_err_en;
    logic irq_txempty_en;
    logic irq_rx_en;
    logic rx_en;
    logic tx_en;
    logic [15:0] div;
  } ctrl_t;
endpackage

// File: rtl/wb_uart_mc_channel.sv
// uart_channel: one 8N1 port with TX/RX FIFOs, control register, sticky flags and interrupt
module uart_channel
  import wb_uart_mc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET = 867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        rd,
  input  logic [1:0]  idx,
  input  logic [20:0] wdat,
  output logic [31:0] rdat,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  ctrl_t ctrl;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] flags;
  logic [2:0] flag_set;
  uart_state_t tx_st, tx_nx, rx_st, rx_nx;
  logic [15:0] tx_div, tx_tmr, rx_div, rx_tmr;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] tx_sh, rx_sh, rx_dout;
  logic rx_s1, rx_s2, rx_s3;
  logic tx_tick, rx_tick, rx_half, tx_full, rx_full, tx_idle, rx_ne;
  logic tx_push_req, tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
  logic [31:0] status;
  assign tx_tick = tx_tmr == tx_div;
  assign rx_tick = rx_tmr == rx_div;
  assign rx_half = rx_tmr == (rx_div >> 1);
  assign tx_full = tx_cnt == CW'(FIFO_DEPTH);
  assign rx_full = rx_cnt == CW'(FIFO_DEPTH);
  assign tx_idle = tx_cnt == '0 && tx_st == IDLE;
  assign rx_ne = rx_cnt != '0;
  // next frame is fetched from IDLE or straight out of the stop bit, so frames run back to back
  assign tx_pop = ctrl.tx_en && tx_cnt != '0 && (tx_st == IDLE || (tx_st == STOP && tx_tick));
  assign tx_push_req = wr && idx == REG_DATA;
  assign tx_push = tx_push_req && (!tx_full || tx_pop);
  assign rx_push_req = rx_st == STOP && rx_tick && rx_s2;
  assign rx_pop = rd && idx == REG_DATA && (rx_ne || rx_push_req);
  assign rx_push = rx_push_req && (!rx_full || rx_pop);
  assign flag_set = {tx_push_req && !tx_push, rx_st == STOP && rx_tick && !rx_s2, rx_push_req && !rx_push};
  assign rx_dout = rx_ne ? rx_mem[rx_rp] : rx_push_req ? rx_sh : 8'd0;
  assign tx = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;
  // status word assembled from live FIFO, shifter and flag state
  always_comb begin
    status = '0;
    status[ST_RX_NE] = rx_ne;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_IDLE] = tx_idle;
    status[ST_TXOVF:ST_RXOVR] = flags;
    status[ST_RX_CNT +: 8] = 8'(rx_cnt);
  end
  // register read mux
  always_comb begin
    rdat = idx == REG_DATA ? {24'd0, rx_dout} :
           idx == REG_STATUS ? status :
           idx == REG_CTRL ? {11'd0, ctrl} : {26'd0, flags, 3'd0};
  end
  // TX frame sequencing
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      IDLE: tx_nx = tx_pop ? START : IDLE;
      START: tx_nx = tx_tick ? DATA : START;
      DATA: tx_nx = tx_tick && tx_bit == 3'd7 ? STOP : DATA;
      default: tx_nx = tx_tick ? (tx_pop ? START : IDLE) : STOP;
    endcase
  end
  // RX frame sequencing; a framing error returns to IDLE, which waits for a fresh falling edge
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      IDLE: rx_nx = ctrl.rx_en && rx_s3 && !rx_s2 ? START : IDLE;
      START: rx_nx = rx_half ? (rx_s2 ? IDLE : DATA) : START;
      DATA: rx_nx = rx_tick && rx_bit == 3'd7 ? STOP : DATA;
      default: rx_nx = rx_tick ? IDLE : STOP;
    endcase
  end
  // state registers for both serial FSMs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st <= IDLE;
      rx_st <= IDLE;
    end else begin
      tx_st <= tx_nx;
      rx_st <= rx_nx;
    end
  end
  // TX bit timer and shifter; divisor is captured when a frame is fetched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_tmr <= '0;
      tx_div <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
    end else begin
      tx_tmr <= (tx_st == IDLE || tx_tick) ? '0 : tx_tmr + 16'd1;
      if (tx_pop) begin
        tx_sh <= tx_mem[tx_rp];
        tx_div <= ctrl.div;
        tx_bit <= '0;
      end else if (tx_st == DATA && tx_tick) begin
        tx_sh <= tx_sh >> 1;
        tx_bit <= tx_bit + 3'd1;
      end
    end
  end
  // RX synchroniser, bit timer and shifter; divisor tracks CTRL only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      rx_tmr <= '0;
      rx_div <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      {rx_s1, rx_s2, rx_s3} <= {rx, rx_s1, rx_s2};
      rx_tmr <= (rx_st == IDLE || (rx_st == START && rx_half) || rx_tick) ? '0 : rx_tmr + 16'd1;
      if (rx_st == IDLE) begin
        rx_div <= ctrl.div;
        rx_bit <= '0;
      end else if (rx_st == DATA && rx_tick) begin
        rx_sh <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end
  end
  // FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdat[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end
  // FIFO pointers, control register, sticky flags and registered interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {tx_wp, tx_rp, rx_wp, rx_rp} <= '0;
      {tx_cnt, rx_cnt} <= '0;
      ctrl <= '{irq_err_en: 1'b0, irq_txempty_en: 1'b0, irq_rx_en: 1'b0, rx_en: 1'b1, tx_en: 1'b1, div: 16'(DIV_RESET)};
      flags <= '0;
      irq <= 1'b0;
    end else begin
      tx_wp <= tx_wp + AW'(tx_push);
      tx_rp <= tx_rp + AW'(tx_pop);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_wp <= rx_wp + AW'(rx_push);
      rx_rp <= rx_rp + AW'(rx_pop);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      if (wr && idx == REG_CTRL)
        ctrl <= '{irq_err_en: wdat[CT_IRQ_ERR], irq_txempty_en: wdat[CT_IRQ_TXE], irq_rx_en: wdat[CT_IRQ_RX],
                  rx_en: wdat[CT_RX_EN], tx_en: wdat[CT_TX_EN], div: wdat[CT_DIV +: 16]};
      flags <= (flags & ~(wr && idx == REG_FLAGS ? wdat[ST_TXOVF:ST_RXOVR] : 3'b000)) | flag_set;
      irq <= (ctrl.irq_rx_en && rx_ne) || (ctrl.irq_txempty_en && tx_idle) || (ctrl.irq_err_en && flags != '0);
    end
  end
endmodule

// File: rtl/wb_uart_mc.sv
// wb_uart_mc: Wishbone slave front end decoding accesses onto CHANNELS independent UARTs
module wb_uart_mc
  import wb_uart_mc_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET = 867
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [CHANNELS-1:0] uart_tx,
  input  logic [CHANNELS-1:0] uart_rx,
  output logic [CHANNELS-1:0] irq
);
  logic [3:0] ch;
  logic [2:0] ri;
  logic req, bad, wr, rd, unused;
  logic [CHANNELS-1:0][31:0] rdat;
  logic [31:0] rsel;
  assign ch = wb_adr_i[8:5];
  assign ri = wb_adr_i[4:2];
  // a request is ignored during its own response cycle so each access acts exactly once
  assign req = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;
  assign bad = {28'd0, ch} >= 32'(CHANNELS) || ri > 3'd3;
  assign wr = req && !bad && wb_we_i && (ri[1:0] != REG_DATA || wb_sel_i[0]);
  assign rd = req && !bad && !wb_we_i;
  assign unused = ^{wb_adr_i[31:9], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:21]};
  // select the addressed channel's read word
  always_comb begin
    rsel = '0;
    for (int c = 0; c < CHANNELS; c++) rsel = {28'd0, ch} == 32'(c) ? rdat[c] : rsel;
  end
  // single-cycle ack/err response with registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req && !bad;
      wb_err_o <= req && bad;
      wb_dat_o <= rd ? rsel : '0;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    uart_channel #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_RESET(DIV_RESET)) u_ch (
      .clk(clk),
      .rst(rst),
      .wr(wr && {28'd0, ch} == 32'(c)),
      .rd(rd && {28'd0, ch} == 32'(c)),
      .idx(ri[1:0]),
      .wdat(wb_dat_i[20:0]),
      .rdat(rdat[c]),
      .rx(uart_rx[c]),
      .tx(uart_tx[c]),
      .irq(irq[c])
    );
  end
endmodule

// File: tb/tb_wb_uart_mc.sv
// tb_wb_uart_mc: randomized scoreboard bench with bus monitor and serial frame decoders
module tb_wb_uart_mc;
  localparam int NCH = 2;
  localparam int DEPTH = 8;
  typedef struct {
    int cyc;
    logic rd;
    logic err;
    logic [31:0] dat;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] adr, dat_i, dat_o;
  logic [3:0] sel;
  logic we, cyc, stb, ack, err, lb;
  logic [NCH-1:0] tx, rx, irq, rx_drv;
  int total = 0;
  int bad_n = 0;
  int cyc_cnt = 0;
  int bl [NCH];
  exp_t exp_q[$];
  exp_t m_e;
  logic [7:0] tx_exp [NCH][$];
  logic [7:0] mq[$];
  logic [7:0] bytes [9];
  logic [31:0] v;

  assign rx = lb ? {rx_drv[1], tx[0]} : rx_drv;

  wb_uart_mc #(.CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .DIV_RESET(867)) dut (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_we_i(we),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err),
    .uart_tx(tx), .uart_rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] st(int n, bit full, bit idle, logic [2:0] fl);
    return {16'd0, 8'(n), 2'd0, fl, idle, full, n != 0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad_n++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic bus(input logic w, input int c, input int r, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_dat, input string nm);
    exp_t e;
    @(negedge clk);
    adr = 32'((c << 5) | (r << 2));
    we = w;
    dat_i = d;
    sel = 4'hf;
    cyc = 1'b1;
    stb = 1'b1;
    e.cyc = cyc_cnt + 1;
    e.rd = !w;
    e.err = e_err;
    e.dat = e_dat;
    e.name = nm;
    exp_q.push_back(e);
    @(negedge clk);
    cyc = 1'b0;
    stb = 1'b0;
    we = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_rx(input int c, input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv[c] = f[i];
      repeat (4) @(negedge clk);
    end
    rx_drv[c] = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // bus monitor: every response must match the head of the queue in the cycle after its request
  always @(negedge clk) begin
    if (ack && err) begin
      total++;
      bad_n++;
      $display("FAIL ack_and_err: both asserted at cycle %0d", cyc_cnt);
    end
    if (exp_q.size() > 0 && cyc_cnt >= exp_q[0].cyc) begin
      m_e = exp_q.pop_front();
      total++;
      if (ack !== !m_e.err || err !== m_e.err || (m_e.rd && !m_e.err && dat_o !== m_e.dat)) begin
        bad_n++;
        $display("FAIL %s: ack=%0b err=%0b dat=%h, want ack=%0b err=%0b dat=%h",
                 m_e.name, ack, err, dat_o, !m_e.err, m_e.err, m_e.dat);
      end
    end else if (ack || err) begin
      total++;
      bad_n++;
      $display("FAIL unexpected_resp: ack=%0b err=%0b at cycle %0d", ack, err, cyc_cnt);
    end
  end

  // serial decoders: each frame is sampled every cycle and must be stable for exactly bl cycles per bit
  for (genvar g = 0; g < NCH; g++) begin : g_dec
    initial begin : dec
      logic prev;
      logic stable;
      logic [9:0] frame;
      logic [7:0] want;
      prev = 1'b1;
      forever begin
        @(negedge clk);
        if (rst === 1'b0 && prev && !tx[g]) begin
          stable = 1'b1;
          frame = '0;
          for (int b = 0; b < 10; b++)
            for (int k = 0; k < bl[g]; k++) begin
              if (b != 0 || k != 0) @(negedge clk);
              if (k == 0) frame[b] = tx[g];
              else if (tx[g] !== frame[b]) stable = 1'b0;
            end
          total++;
          if (tx_exp[g].size() == 0) begin
            bad_n++;
            $display("FAIL tx%0d_frame: unexpected frame %b", g, frame);
          end else begin
            want = tx_exp[g].pop_front();
            if (!stable || frame !== {1'b1, want, 1'b0}) begin
              bad_n++;
              $display("FAIL tx%0d_frame: got %b stable=%0b want %b", g, frame, stable, {1'b1, want, 1'b0});
            end
          end
          prev = tx[g];
        end else prev = tx[g];
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r;
    rst = 1'b1;
    lb = 1'b0;
    rx_drv = '1;
    {cyc, stb, we} = 3'b000;
    adr = '0;
    dat_i = '0;
    sel = '0;
    bl = '{868, 868};
    wait_cyc(3);
    chk("rst_tx", 32'(tx), 32'(2'b11));
    chk("rst_irq", 32'(irq), 0);
    chk("rst_ack_err", {30'd0, ack, err}, 0);
    chk("rst_dat", dat_o, 0);
    rst = 1'b0;
    wait_cyc(2);
    bus(0, 0, 2, 0, 0, 32'h0003_0363, "ctrl0_reset");
    bus(0, 1, 2, 0, 0, 32'h0003_0363, "ctrl1_reset");
    bus(0, 3, 0, 0, 1, 0, "bad_channel");
    bus(0, 0, 5, 0, 1, 0, "bad_register");
    bus(0, 0, 1, 0, 0, st(0, 0, 1, 0), "status0_reset");

    for (int i = 0; i < 20; i++) begin
      c = $urandom_range(0, 1);
      v = ($urandom & 32'h001f_0000) | 32'($urandom_range(2, 20));
      bus(1, c, 2, v | ($urandom & 32'hffe0_0000), 0, 0, "ctrl_write");
      bl[c] = int'(v[15:0]) + 1;
      bus(0, c, 2, 0, 0, v, "ctrl_readback");
      c = $urandom_range(0, 15);
      r = c < NCH ? $urandom_range(4, 7) : $urandom_range(0, 7);
      bus(1'($urandom_range(0, 1)), c, r, $urandom, 1, 0, "bad_access");
    end

    for (int i = 0; i < NCH; i++) begin
      bus(1, i, 2, 32'h0003_0003, 0, 0, "ctrl_div3");
      bl[i] = 4;
      bus(1, i, 3, 32'h38, 0, 0, "flags_clear_all");
    end
    tx_exp[1].push_back(8'ha5);
    bus(1, 1, 0, 32'ha5, 0, 0, "tx1_write_a5");
    wait_cyc(60);
    bus(0, 1, 1, 0, 0, st(0, 0, 1, 0), "status1_after_a5");

    lb = 1'b1;
    foreach (bytes[i]) bytes[i] = (i == 0) ? 8'h3c : (i == 1) ? 8'h81 : 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      tx_exp[0].push_back(bytes[i]);
      mq.push_back(bytes[i]);
      bus(1, 0, 0, {24'd0, bytes[i]}, 0, 0, "lb_write");
    end
    wait_cyc(100);
    bus(0, 0, 1, 0, 0, st(2, 0, 1, 0), "lb_status_two");
    while (mq.size() > 0) bus(0, 0, 0, 0, 0, {24'd0, mq.pop_front()}, "lb_read");
    bus(0, 0, 0, 0, 0, 0, "lb_read_empty");
    for (int i = 2; i < 5; i++) begin
      tx_exp[0].push_back(bytes[i]);
      mq.push_back(bytes[i]);
      bus(1, 0, 0, {24'd0, bytes[i]}, 0, 0, "lb_write_rand");
    end
    wait_cyc(150);
    bus(0, 0, 1, 0, 0, st(3, 0, 1, 0), "lb_status_three");
    while (mq.size() > 0) bus(0, 0, 0, 0, 0, {24'd0, mq.pop_front()}, "lb_read_rand");
    bus(0, 0, 1, 0, 0, st(0, 0, 1, 0), "lb_status_drained");
    lb = 1'b0;

    bus(1, 1, 2, 32'h0002_0003, 0, 0, "tx1_disable");
    foreach (bytes[i]) begin
      bytes[i] = 8'($urandom);
      bus(1, 1, 0, {24'd0, bytes[i]}, 0, 0, "fill_write");
    end
    bus(0, 1, 1, 0, 0, st(0, 1, 0, 3'b100), "status_full_txovf");
    bus(0, 1, 3, 0, 0, 32'h20, "flags_txovf");
    bus(1, 1, 3, 32'h20, 0, 0, "flags_clear_txovf");
    bus(0, 1, 1, 0, 0, st(0, 1, 0, 3'b000), "status_txovf_cleared");
    for (int i = 0; i < DEPTH; i++) tx_exp[1].push_back(bytes[i]);
    bus(1, 1, 2, 32'h0003_0003, 0, 0, "tx1_enable");
    wait_cyc(360);
    chk("tx1_frames_left", 32'(tx_exp[1].size()), 0);
    bus(0, 1, 1, 0, 0, st(0, 0, 1, 0), "status_after_drain");

    bus(1, 1, 2, 32'h0013_0003, 0, 0, "irq_err_enable");
    chk("irq1_quiet", 32'(irq[1]), 0);
    send_rx(1, 8'($urandom), 1'b0);
    wait_cyc(10);
    bus(0, 1, 1, 0, 0, st(0, 0, 1, 3'b010), "status_framing");
    chk("irq1_framing", 32'(irq[1]), 1);
    bus(1, 1, 3, 32'h10, 0, 0, "flags_clear_framing");
    wait_cyc(2);
    chk("irq1_cleared", 32'(irq[1]), 0);

    rx_drv[1] = 1'b0;
    @(negedge clk);
    rx_drv[1] = 1'b1;
    wait_cyc(60);
    bus(0, 1, 1, 0, 0, st(0, 0, 1, 0), "status_after_glitch");
    chk("irq1_glitch", 32'(irq[1]), 0);

    foreach (bytes[i]) begin
      bytes[i] = 8'($urandom);
      if (i < DEPTH) mq.push_back(bytes[i]);
      send_rx(1, bytes[i], 1'b1);
    end
    wait_cyc(10);
    bus(0, 1, 1, 0, 0, st(DEPTH, 0, 1, 3'b001), "status_rxovr");
    chk("irq1_rxovr", 32'(irq[1]), 1);
    while (mq.size() > 0) bus(0, 1, 0, 0, 0, {24'd0, mq.pop_front()}, "rx_full_read");
    bus(0, 1, 0, 0, 0, 0, "rx_ninth_lost");
    bus(1, 1, 3, 32'h08, 0, 0, "flags_clear_rxovr");
    bus(0, 1, 1, 0, 0, st(0, 0, 1, 0), "status_final");

    wait_cyc(20);
    chk("bus_queue_empty", 32'(exp_q.size()), 0);
    chk("tx0_queue_empty", 32'(tx_exp[0].size()), 0);
    chk("tx1_queue_empty", 32'(tx_exp[1].size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end
endmodule
